// File: rtl/lcd_rx_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_rx_capture: HS/VS/DE/RGB565 stream capture with frame geometry checks
// Revision 1.0
// ---------------------------------------------------------------------------
module lcd_rx_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter bit DE_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic [15:0] in_rgb,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [10:0] pix_xpos,
  output logic [10:0] pix_ypos,
  output logic        frame_start,
  output logic        line_end,
  output logic        frame_done,
  output logic        frame_err,
  output logic [10:0] h_active_meas,
  output logic [10:0] v_active_meas,
  output logic [11:0] h_total_meas,
  output logic [7:0]  err_count
);

  localparam logic [1:0]  C_IDLE     = 2'd0;
  localparam logic [1:0]  C_SYNC     = 2'd1;
  localparam logic [1:0]  C_ACTIVE   = 2'd2;
  localparam logic [10:0] C_H_ACTIVE = 11'(H_ACTIVE);
  localparam logic [10:0] C_V_ACTIVE = 11'(V_ACTIVE);
  localparam logic [10:0] C_MAX      = 11'h7FF;

  logic        r_hs1, r_vs1, r_de1, r_hs2, r_vs2, r_de2;
  logic [15:0] r_rgb1;
  logic [1:0]  r_state, w_state_nxt;
  logic [10:0] r_x, r_y, w_x_nxt, w_y_nxt, w_y_closed;
  logic        r_bad, w_bad_nxt, w_frame_bad;
  logic [11:0] r_hcnt;
  logic        w_vs_edge, w_hs_edge, w_de_fall, w_pix, w_line_close, w_frame_close;

  // Syncs are normalised to active-high at the first register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
      r_de1  <= 1'b0;
      r_hs2  <= 1'b0;
      r_vs2  <= 1'b0;
      r_de2  <= 1'b0;
      r_rgb1 <= '0;
    end else begin
      r_hs1  <= (in_hs == HS_POL);
      r_vs1  <= (in_vs == VS_POL);
      r_de1  <= (in_de == DE_POL);
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_de2  <= r_de1;
      r_rgb1 <= in_rgb;
    end
  end

  assign w_vs_edge     = r_vs1 & ~r_vs2;
  assign w_hs_edge     = r_hs1 & ~r_hs2;
  assign w_de_fall     = ~r_de1 & r_de2;
  assign w_pix         = (r_state != C_IDLE) & r_de1 & ~r_vs1;
  assign w_line_close  = (r_state == C_ACTIVE) & w_de_fall;
  assign w_frame_close = (r_state == C_ACTIVE) & w_vs_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= C_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE:   if (w_vs_edge) w_state_nxt = C_SYNC;
      C_SYNC:   if (w_vs_edge) w_state_nxt = C_SYNC;
                else if (w_pix) w_state_nxt = C_ACTIVE;
      C_ACTIVE: if (w_vs_edge) w_state_nxt = C_SYNC;
      default:  w_state_nxt = C_IDLE;
    endcase
  end

  // A line closing together with the VS edge is folded in before the frame is judged
  always_comb begin
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    w_bad_nxt = r_bad;
    if (w_pix) begin
      if (r_x == C_MAX) w_bad_nxt = 1'b1;
      else              w_x_nxt   = r_x + 11'd1;
    end
    if (w_line_close) begin
      w_x_nxt = '0;
      if (r_x != C_H_ACTIVE) w_bad_nxt = 1'b1;
      if (r_y == C_MAX) w_bad_nxt = 1'b1;
      else              w_y_nxt   = r_y + 11'd1;
    end
    w_y_closed  = w_y_nxt;
    w_frame_bad = w_bad_nxt | (w_y_nxt != C_V_ACTIVE);
    if (w_frame_close) begin
      w_x_nxt   = '0;
      w_y_nxt   = '0;
      w_bad_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid     <= 1'b0;
      pix_data      <= '0;
      pix_xpos      <= '0;
      pix_ypos      <= '0;
      frame_start   <= 1'b0;
      line_end      <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      h_active_meas <= '0;
      v_active_meas <= '0;
      h_total_meas  <= '0;
      err_count     <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_bad         <= 1'b0;
      r_hcnt        <= '0;
    end else begin
      pix_valid   <= w_pix;
      frame_start <= w_pix & (r_state == C_SYNC);
      line_end    <= w_line_close;
      frame_done  <= w_frame_close;
      frame_err   <= w_frame_close & w_frame_bad;
      if (w_pix) begin
        pix_data <= r_rgb1;
        pix_xpos <= r_x;
        pix_ypos <= r_y;
      end
      if (w_line_close)  h_active_meas <= r_x;
      if (w_frame_close) v_active_meas <= w_y_closed;
      if (w_frame_close && w_frame_bad && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_bad <= w_bad_nxt;
      if (w_hs_edge) begin
        h_total_meas <= r_hcnt;
        r_hcnt       <= 12'd1;
      end else if (r_hcnt != 12'hFFF) begin
        r_hcnt <= r_hcnt + 12'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_rx_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lcd_rx_capture: randomized stream bench with a frame-level reference model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_lcd_rx_capture;

  localparam int H = 8;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_hs, in_vs, in_de;
  logic [15:0] in_rgb;
  logic        pix_valid, frame_start, line_end, frame_done, frame_err;
  logic [15:0] pix_data;
  logic [10:0] pix_xpos, pix_ypos, h_active_meas, v_active_meas;
  logic [11:0] h_total_meas;
  logic [7:0]  err_count;

  lcd_rx_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .HS_POL(1'b0), .VS_POL(1'b0), .DE_POL(1'b1)) dut (
    .clk(clk), .rst(rst), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .in_rgb(in_rgb),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_xpos(pix_xpos), .pix_ypos(pix_ypos),
    .frame_start(frame_start), .line_end(line_end), .frame_done(frame_done),
    .frame_err(frame_err), .h_active_meas(h_active_meas), .v_active_meas(v_active_meas),
    .h_total_meas(h_total_meas), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [15:0] data;
    logic [10:0] x, y;
    logic        fs, le, fd, fe;
    logic [10:0] ham, vam;
    logic [11:0] htm;
    logic [7:0]  ec;
  } exp_t;

  int   n_chk = 0, n_fail = 0, cyc = 0;
  exp_t e_cur, e_pend;
  // reference model state: frame-level counts, not a register-level copy
  logic p_hs, p_vs, p_de, armed, in_frame, fbad;
  int   col, row, n, last_hs_n, m_ec;
  // observation counters
  int   pix_cnt, fs_cnt, le_cnt, fd_cnt, fe_cnt, saw2047, first_pix_cyc, de_drive_cyc;
  logic [15:0] last_data, pix_seq;
  logic [10:0] last_x, last_y;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic ch, cv, cd;
    if (rst) begin
      e_cur = '0; e_pend = '0;
      p_hs = 1'b0; p_vs = 1'b0; p_de = 1'b0;
      armed = 1'b0; in_frame = 1'b0; fbad = 1'b0;
      col = 0; row = 0; n = 0; last_hs_n = 0; m_ec = 0;
    end else begin
      e_cur = e_pend;
      e_pend.valid = 1'b0; e_pend.fs = 1'b0; e_pend.le = 1'b0;
      e_pend.fd = 1'b0; e_pend.fe = 1'b0;
      n++;
      ch = (in_hs == 1'b0);
      cv = (in_vs == 1'b0);
      cd = (in_de == 1'b1);
      if (ch && !p_hs) begin
        e_pend.htm = 12'(min_i(n - last_hs_n, 4095));
        last_hs_n  = n;
      end
      if (armed && cd && !cv) begin
        e_pend.valid = 1'b1;
        e_pend.data  = in_rgb;
        e_pend.x     = 11'(min_i(col, 2047));
        e_pend.y     = 11'(min_i(row, 2047));
        e_pend.fs    = !in_frame;
        in_frame     = 1'b1;
        col++;
      end
      if (in_frame && !cd && p_de) begin
        e_pend.le  = 1'b1;
        e_pend.ham = 11'(min_i(col, 2047));
        if (col != H) fbad = 1'b1;
        row++;
        col = 0;
      end
      if (cv && !p_vs) begin
        if (in_frame) begin
          e_pend.fd  = 1'b1;
          e_pend.vam = 11'(min_i(row, 2047));
          if (fbad || row != V) begin
            e_pend.fe = 1'b1;
            if (m_ec < 255) m_ec++;
          end
          e_pend.ec = 8'(m_ec);
        end
        in_frame = 1'b0; col = 0; row = 0; fbad = 1'b0; armed = 1'b1;
      end
      p_hs = ch; p_vs = cv; p_de = cd;
    end
  endtask

  task automatic compare();
    chk("pix_valid", 16'(pix_valid), 16'(e_cur.valid));
    if (e_cur.valid) begin
      chk("pix_data", pix_data, e_cur.data);
      chk("pix_xpos", 16'(pix_xpos), 16'(e_cur.x));
      chk("pix_ypos", 16'(pix_ypos), 16'(e_cur.y));
    end
    chk("frame_start", 16'(frame_start), 16'(e_cur.fs));
    chk("line_end", 16'(line_end), 16'(e_cur.le));
    chk("frame_done", 16'(frame_done), 16'(e_cur.fd));
    chk("frame_err", 16'(frame_err), 16'(e_cur.fe));
    chk("h_active_meas", 16'(h_active_meas), 16'(e_cur.ham));
    chk("v_active_meas", 16'(v_active_meas), 16'(e_cur.vam));
    chk("h_total_meas", 16'(h_total_meas), 16'(e_cur.htm));
    chk("err_count", 16'(err_count), 16'(e_cur.ec));
    if (pix_valid) begin
      pix_cnt++;
      last_data = pix_data; last_x = pix_xpos; last_y = pix_ypos;
      if (pix_xpos == 11'h7FF) saw2047 = 1;
      if (first_pix_cyc < 0) first_pix_cyc = cyc;
    end
    if (frame_start) fs_cnt++;
    if (line_end)    le_cnt++;
    if (frame_done)  fd_cnt++;
    if (frame_err)   fe_cnt++;
  endtask

  initial forever begin @(posedge clk or posedge rst); model_step(); end
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin @(negedge clk); compare(); end

  task automatic clr_cnt();
    pix_cnt = 0; fs_cnt = 0; le_cnt = 0; fd_cnt = 0; fe_cnt = 0; saw2047 = 0;
  endtask

  task automatic step(input logic hs, input logic vs, input logic de, input logic [15:0] rgb);
    in_hs = hs; in_vs = vs; in_de = de; in_rgb = rgb;
    if (de && de_drive_cyc < 0) de_drive_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic vsync(input logic de_mid);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, de_mid, 16'($urandom));
    step(1'b1, 1'b0, de_mid, 16'($urandom));
    step(1'b1, 1'b0, 1'b0, 16'h0);
    idle(2);
  endtask

  task automatic line(input int len, input logic inc);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    idle(int'($urandom_range(1, 3)));
    for (int i = 0; i < len; i++) begin
      step(1'b1, 1'b1, 1'b1, inc ? pix_seq : 16'($urandom));
      if (inc) pix_seq++;
    end
    idle(int'($urandom_range(1, 3)));
  endtask

  task automatic frame(input int lines, input int short_idx, input int short_len, input logic inc);
    for (int l = 0; l < lines; l++) line((l == short_idx) ? short_len : H, inc);
  endtask

  initial begin
    rst = 1'b1; in_hs = 1'b1; in_vs = 1'b1; in_de = 1'b0; in_rgb = '0;
    pix_seq = '0; de_drive_cyc = -1; first_pix_cyc = -1;
    last_data = '0; last_x = '0; last_y = '0;
    clr_cnt();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pix_valid", 16'(pix_valid), 16'd0);
    chk("reset_err_count", 16'(err_count), 16'd0);
    chk("reset_h_total", 16'(h_total_meas), 16'd0);
    rst = 1'b0;

    // clean frames with incrementing data
    idle(3);
    clr_cnt(); de_drive_cyc = -1; first_pix_cyc = -1;
    vsync(1'b0);
    frame(V, -1, 0, 1'b1);
    vsync(1'b0);
    chk("t1_pix_cnt", 16'(pix_cnt), 16'd32);
    chk("t1_frame_start_cnt", 16'(fs_cnt), 16'd1);
    chk("t1_line_end_cnt", 16'(le_cnt), 16'd4);
    chk("t1_frame_done_cnt", 16'(fd_cnt), 16'd1);
    chk("t1_frame_err_cnt", 16'(fe_cnt), 16'd0);
    chk("t1_h_active", 16'(h_active_meas), 16'd8);
    chk("t1_v_active", 16'(v_active_meas), 16'd4);
    chk("t1_err_count", 16'(err_count), 16'd0);
    chk("t1_last_x", 16'(last_x), 16'd7);
    chk("t1_last_y", 16'(last_y), 16'd3);
    chk("t1_last_data", last_data, 16'd31);
    chk("t1_latency", 16'(first_pix_cyc - de_drive_cyc), 16'd2);
    frame(V, -1, 0, 1'b1);
    vsync(1'b0);
    chk("t1_frame2_done_cnt", 16'(fd_cnt), 16'd2);
    chk("t1_frame2_err_cnt", 16'(fe_cnt), 16'd0);

    // reset released in the middle of a frame
    rst = 1'b1;
    line(H, 1'b0);
    rst = 1'b0;
    clr_cnt();
    line(H, 1'b0);
    line(H, 1'b0);
    chk("t2_partial_pix_cnt", 16'(pix_cnt), 16'd0);
    vsync(1'b0);
    chk("t2_partial_done_cnt", 16'(fd_cnt), 16'd0);
    frame(V, -1, 0, 1'b0);
    vsync(1'b0);
    chk("t2_done_cnt", 16'(fd_cnt), 16'd1);
    chk("t2_err_cnt", 16'(fe_cnt), 16'd0);

    // one short line
    clr_cnt();
    frame(V, 1, 7, 1'b0);
    vsync(1'b0);
    chk("t3_err_cnt", 16'(fe_cnt), 16'd1);
    chk("t3_err_count", 16'(err_count), 16'd1);
    chk("t3_h_active", 16'(h_active_meas), 16'd8);
    frame(V, -1, 0, 1'b0);
    idle(4);
    clr_cnt();
    vsync(1'b1);
    chk("t3_clean_done_cnt", 16'(fd_cnt), 16'd1);
    chk("t3_clean_err_cnt", 16'(fe_cnt), 16'd0);
    chk("t4_de_in_vs_pix_cnt", 16'(pix_cnt), 16'd0);

    // five-line frame
    frame(5, -1, 0, 1'b0);
    vsync(1'b0);
    chk("t4_v_active", 16'(v_active_meas), 16'd5);
    chk("t4_err_cnt", 16'(fe_cnt), 16'd1);
    chk("t4_err_count", 16'(err_count), 16'd2);
    chk("t4_pix_cnt", 16'(pix_cnt), 16'd40);

    // HS period and overlong line
    repeat (4) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      idle(10);
    end
    chk("t5_h_total", 16'(h_total_meas), 16'd12);
    clr_cnt();
    repeat (2100) step(1'b1, 1'b1, 1'b1, 16'($urandom));
    idle(3);
    vsync(1'b0);
    chk("t5_saw_x2047", 16'(saw2047), 16'd1);
    chk("t5_err_cnt", 16'(fe_cnt), 16'd1);
    chk("t5_h_active", 16'(h_active_meas), 16'd2047);
    chk("t5_v_active", 16'(v_active_meas), 16'd1);
    chk("t5_err_count", 16'(err_count), 16'd3);

    // asynchronous reset during an active line
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    repeat (3) step(1'b1, 1'b1, 1'b1, 16'($urandom));
    #2 rst = 1'b1;
    #1;
    chk("t6_async_pix_valid", 16'(pix_valid), 16'd0);
    chk("t6_async_err_count", 16'(err_count), 16'd0);
    chk("t6_async_h_active", 16'(h_active_meas), 16'd0);
    chk("t6_async_v_active", 16'(v_active_meas), 16'd0);
    chk("t6_async_h_total", 16'(h_total_meas), 16'd0);
    chk("t6_async_pix_xpos", 16'(pix_xpos), 16'd0);
    in_de = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    clr_cnt();
    idle(2);
    line(H, 1'b0);
    idle(3);
    chk("t6_idle_pix_cnt", 16'(pix_cnt), 16'd0);
    vsync(1'b0);
    frame(V, -1, 0, 1'b0);
    vsync(1'b0);
    chk("t6_done_cnt", 16'(fd_cnt), 16'd1);
    chk("t6_err_cnt", 16'(fe_cnt), 16'd0);
    chk("t6_err_count", 16'(err_count), 16'd0);

    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
